// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and widths for the AES job arbiter
package aes_pkg;

    localparam int AES_KEY_W   = 128;
    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUSY,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/aes_arbiter_if.sv
// rtl/aes_arbiter_if.sv - requester, response and core-side signals of the AES arbiter
interface aes_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                            req_valid_i;
    logic [NUM_REQ-1:0]                            req_ready_o;
    logic [NUM_REQ-1:0]                            req_encdec_i;
    logic [NUM_REQ-1:0][aes_pkg::AES_KEY_W-1:0]    req_key_i;
    logic [NUM_REQ-1:0][aes_pkg::AES_BLOCK_W-1:0]  req_block_i;

    logic [NUM_REQ-1:0]                            resp_valid_o;
    logic [NUM_REQ-1:0]                            resp_ready_i;
    logic [aes_pkg::AES_BLOCK_W-1:0]               resp_result_o;
    logic                                          resp_err_o;

    logic                                          core_on_o;
    logic                                          core_encdec_o;
    logic [aes_pkg::AES_KEY_W-1:0]                 core_key_o;
    logic [aes_pkg::AES_BLOCK_W-1:0]               core_block_o;
    logic [aes_pkg::AES_BLOCK_W-1:0]               core_result_i;
    logic                                          core_valid_i;

    modport slave (
        input  req_valid_i, req_encdec_i, req_key_i, req_block_i, resp_ready_i,
        input  core_result_i, core_valid_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_err_o,
        output core_on_o, core_encdec_o, core_key_o, core_block_o
    );

    modport master (
        output req_valid_i, req_encdec_i, req_key_i, req_block_i, resp_ready_i,
        output core_result_i, core_valid_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_err_o,
        input  core_on_o, core_encdec_o, core_key_o, core_block_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                                  req_i,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]    last_i,
    output logic [NUM_REQ-1:0]                                  grant_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]    idx_o,
    output logic                                                any_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int cand;

    // Scan last+1 .. last+NUM_REQ so the previous winner is considered last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_i) + i) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
    end
endmodule

// File: rtl/aes_arbiter.sv
// rtl/aes_arbiter.sv - shares one AES core among NUM_REQ requesters with timeout abort
module aes_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    aes_arbiter_if.slave bus,
    output logic         busy_o,
    output logic [15:0]  done_cnt_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          last_q, id_q, grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic                   grant_any;
    logic [TW-1:0]          timer_q;
    logic [AES_BLOCK_W-1:0] result_q;
    logic                   err_q;
    logic [AES_KEY_W-1:0]   key_q;
    logic [AES_BLOCK_W-1:0] block_q;
    logic                   encdec_q;
    logic [15:0]            done_q;
    logic                   accept, core_done, timed_out, release_job;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (bus.req_valid_i),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        core_done   = 1'b0;
        timed_out   = 1'b0;
        release_job = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any && !rst_i) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_BUSY;
            ST_BUSY: begin
                // A result arriving on the timeout cycle still counts as success.
                if (bus.core_valid_i) begin
                    core_done = 1'b1;
                    state_d   = ST_RESP;
                end else if (timer_q == T_LAST) begin
                    timed_out = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready_i[id_q]) begin
                    release_job = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q   <= IW'(NUM_REQ - 1);
            id_q     <= '0;
            timer_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            key_q    <= '0;
            block_q  <= '0;
            encdec_q <= 1'b0;
            done_q   <= '0;
        end else begin
            if (accept) begin
                id_q     <= grant_idx;
                key_q    <= bus.req_key_i[grant_idx];
                block_q  <= bus.req_block_i[grant_idx];
                encdec_q <= bus.req_encdec_i[grant_idx];
            end
            if (state_q == ST_LOAD)
                timer_q <= '0;
            else if (state_q == ST_BUSY && !core_done && !timed_out)
                timer_q <= timer_q + 1'b1;
            if (core_done) begin
                result_q <= bus.core_result_i;
                err_q    <= 1'b0;
            end else if (timed_out) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end
            if (release_job) begin
                last_q <= id_q;
                done_q <= done_q + 16'd1;
            end
        end
    end

    assign bus.req_ready_o   = accept ? grant : '0;
    assign bus.resp_valid_o  = (state_q == ST_RESP) ? (NUM_REQ'(1) << id_q) : '0;
    assign bus.resp_result_o = result_q;
    assign bus.resp_err_o    = err_q;
    assign bus.core_on_o     = (state_q == ST_LOAD);
    assign bus.core_encdec_o = encdec_q;
    assign bus.core_key_o    = key_q;
    assign bus.core_block_o  = block_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign done_cnt_o        = done_q;
endmodule
